// File: rtl/cross_bar_pkg.sv
// Shared types and sizing for the cross bar fabric.
// Master/slave counts, address/data widths and grant vectors.
package cross_bar_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int SLAVE_N  = 4;
    localparam int MASTER_N = 4;
    localparam int SSEL_W   = $clog2(SLAVE_N);
    localparam int MIDX_W   = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [SLAVE_N-1:0]  sgrant_t;
    typedef logic [MASTER_N-1:0] mgrant_t;
    typedef logic [MIDX_W-1:0]   midx_t;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } slv_state_t;

    // Round-robin successor of a master index, wrapping at MASTER_N.
    function automatic midx_t next_midx(midx_t i);
        if (int'(i) == MASTER_N - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

endpackage

// File: rtl/cross_bar_rr_arb.sv
// Combinational round-robin picker: lowest requester at or above ptr,
// searching upward with wrap-around; produces a one-hot winner.
module cross_bar_rr_arb #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/cross_bar_slave.sv
// Slave-port arbiter: round-robin grant among masters decoding to this
// slave, grant held until slave_ack, request forwarded via AND-OR mux.
module cross_bar_slave
    import cross_bar_pkg::*;
#(
    parameter int SLAVE_ID = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MASTER_N-1:0]        master_req,
    input  addr_t [MASTER_N-1:0]       master_addr,
    input  logic [MASTER_N-1:0]        master_cmd,
    input  data_t [MASTER_N-1:0]       master_wdata,
    output logic                       slave_req,
    output addr_t                      slave_addr,
    output logic                       slave_cmd,
    output data_t                      slave_wdata,
    input  logic                       slave_ack,
    output logic [MASTER_N-1:0]        mgrant
);

    slv_state_t state, state_d;
    mgrant_t    mgrant_d;
    mgrant_t    hit;
    mgrant_t    win;
    logic       any_hit;
    midx_t      rr_ptr, rr_ptr_d;
    midx_t      gidx;

    always_comb begin
        hit = '0;
        for (int m = 0; m < MASTER_N; m++) begin
            hit[m] = master_req[m] &&
                (master_addr[m][ADDR_W-1 -: SSEL_W] == SSEL_W'(SLAVE_ID));
        end
    end

    cross_bar_rr_arb #(
        .N  (MASTER_N),
        .PW (MIDX_W)
    ) u_arb (
        .req   (hit),
        .ptr   (rr_ptr),
        .grant (win),
        .any   (any_hit)
    );

    // Index of the currently granted master (mgrant is one-hot).
    always_comb begin
        gidx = '0;
        for (int m = 0; m < MASTER_N; m++) begin
            if (mgrant[m]) begin
                gidx = MIDX_W'(m);
            end
        end
    end

    always_comb begin
        state_d  = state;
        mgrant_d = mgrant;
        rr_ptr_d = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (any_hit) begin
                    mgrant_d = win;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (slave_ack) begin
                    mgrant_d = '0;
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_midx(gidx);
                end
            end
            default: begin
                mgrant_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            mgrant <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_d;
            mgrant <= mgrant_d;
            rr_ptr <= rr_ptr_d;
        end
    end

    assign slave_req = (state == ST_BUSY);

    // AND-OR forwarding: all zero whenever nothing is granted.
    always_comb begin
        slave_addr  = '0;
        slave_cmd   = 1'b0;
        slave_wdata = '0;
        for (int m = 0; m < MASTER_N; m++) begin
            slave_addr  = slave_addr  | (master_addr[m]  & {ADDR_W{mgrant[m]}});
            slave_cmd   = slave_cmd   | (master_cmd[m]   & mgrant[m]);
            slave_wdata = slave_wdata | (master_wdata[m] & {DATA_W{mgrant[m]}});
        end
    end

    a_grant_onehot: assert property (
        @(posedge clk) disable iff (rst) $onehot0(mgrant)
    );

    a_req_matches_grant: assert property (
        @(posedge clk) disable iff (rst) slave_req == (|mgrant)
    );

endmodule

// File: doc/cross_bar_slave.md
Name: cross_bar_slave

Overview:
Slave-side arbiter and request forwarder for the cross bar; one instance per slave port. It picks one of MASTER_N masters whose address decodes to this slave, using round-robin, and forwards that master's request to the slave. Grant is held until the slave acks. Its registered one-hot grant vector, transposed at top level, drives the sgrant inputs of the master-side response muxes, which return ack/rdata.

Parameters:
SLAVE_ID, 0, index of this slave; matched against the slave-select field of master_addr
MASTER_N, cross_bar_pkg::MASTER_N (4), number of masters (localparam from package)
SLAVE_N, cross_bar_pkg::SLAVE_N (4), number of slaves (localparam from package)

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  asynchronous, active-high reset
master_req  input  [MASTER_N]  per-master request, held until that master sees ack
master_addr  input  addr_t[MASTER_N]  per-master address; top SSEL_W bits select slave
master_cmd  input  [MASTER_N]  1 = write, 0 = read
master_wdata  input  data_t[MASTER_N]  per-master write data
slave_req  output  1  request to slave
slave_addr  output  addr_t  forwarded address of granted master
slave_cmd  output  1  forwarded command
slave_wdata  output  data_t  forwarded write data
slave_ack  input  1  single-cycle completion from slave
mgrant  output  [MASTER_N]  one-hot registered grant; bit m feeds sgrant[SLAVE_ID] of master m

Behaviour:
- Reset (async, active-high): state=IDLE, mgrant=0, slave_req=0, rr pointer=0. Forwarded data outputs are 0 while mgrant=0 (AND-OR mux).
- Decode: hit[m] = master_req[m] && master_addr[m][ADDR_W-1 -: SSEL_W] == SLAVE_ID.
- FSM IDLE: if any hit, mgrant <= round-robin winner; state <= BUSY. Search starts at rr pointer and goes upward with wrap-around. Otherwise stay in IDLE.
- FSM BUSY: slave_req=1. slave_addr/cmd/wdata = AND-OR mux of the granted master's inputs.
- On slave_ack in BUSY: mgrant stays asserted during the ack cycle, so the master mux returns ack/rdata that cycle. Next edge: mgrant <= 0, state <= IDLE, rr pointer <= granted index + 1 mod MASTER_N.
- Latency: req seen at edge N -> mgrant/slave_req high after edge N. Ack in cycle K -> slave_req low in cycle K+1. The next grant is visible no earlier than cycle K+2: one mandatory bubble, so the finishing master can drop its req.
- Ack in the same cycle as the grant edge is legal: the transaction ends after one BUSY cycle.
- slave_ack in IDLE is ignored. Requests changing while BUSY do not affect the grant; no preemption.
- Request withdrawn while BUSY is a protocol violation: the grant is held until slave_ack, and the bench asserts on it.
- Simultaneous hits: the winner is strictly the lowest index at or above the rr pointer. No master waits more than MASTER_N-1 grants.
- Reset mid-transaction: outputs clear immediately (async). No ack is forwarded afterward; in-flight slave state is the slave's concern.
- Assertions: $onehot0(mgrant); slave_req == |mgrant.

Decomposition:
- cross_bar_pkg gains: MASTER_N, SSEL_W = $clog2(SLAVE_N), mgrant_t = logic [MASTER_N-1:0]. addr_t, data_t, ADDR_W, DATA_W and sgrant_t are reused.
- Sub-module cross_bar_rr_arb: combinational round-robin pick (req vector, pointer -> one-hot winner). This is reusable by future arbiters.
- The FSM, pointer and forwarding mux stay in cross_bar_slave.

Test Plan:
- Reset: assert rst mid-BUSY with master 2 granted -> mgrant=0000 and slave_req=0 within the same cycle; after release, rr pointer=0.
- Single master: master 1 requests addr with slave field=SLAVE_ID, cmd=1, wdata=0xDEADBEEF -> next cycle mgrant=0010, slave_wdata=0xDEADBEEF, slave_cmd=1. Ack 3 cycles later -> mgrant=0000 the following cycle.
- Decode filter: master 0 requests with slave field=SLAVE_ID+1 -> mgrant stays 0000 and slave_req stays 0 for 10 cycles.
- Round-robin: masters 0..3 request continuously, slave acks each immediately -> grant order 0,1,2,3,0, with one idle cycle between grants.
- Same-cycle ack: slave_ack is high in the first BUSY cycle -> one-cycle transaction, then IDLE for one cycle, then the next requester is granted.
- Hold: master 3 granted, master 0 raises req, no ack for 20 cycles -> mgrant stays 1000 and slave_addr is unchanged throughout.
